// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, mult/div results queue in a FIFO.
// Optional zero-latency bypass of mult/div results into idle slots: define RF_ARB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0] md_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_pending,
  output logic              rt_pending,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              stall_req,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STV_LAST = STV_W'(STARVE_MAX - 1);

  logic [DEPTH-1:0]  live_q, live_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              stall_q, stall_d;

  logic fifo_empty, wb_act, grant_head, bypass, push, pop;

  assign fifo_empty = (count_q == '0);
  assign wb_act     = wb_we && (wb_addr != '0);
  assign md_ready   = rst_n && (count_q < DEPTH_C);
  // During a stall the WB write is held upstream, so the head wins even over an active WB.
  assign grant_head = !fifo_empty && (stall_q || !wb_act);
  assign pop        = rst_n && grant_head;
  assign push       = md_valid && md_ready && (md_addr != '0) && !bypass;
  assign stall_req  = stall_q;
  assign busy       = !fifo_empty;

  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no latch can be inferred.
    bypass  = 1'b0;
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_data = '0;
`ifdef RF_ARB_BYPASS_EN
    bypass = rst_n && fifo_empty && !wb_act && !stall_q && md_valid && (md_addr != '0);
`endif
    if (rst_n) begin
      if (grant_head) begin
        rf_we   = live_q[rd_ptr_q];
        rf_addr = addr_q[rd_ptr_q];
        rf_data = data_q[rd_ptr_q];
      end else if (wb_act) begin
        rf_we   = 1'b1;
        rf_addr = wb_addr;
        rf_data = wb_data;
      end else if (bypass) begin
        rf_we   = 1'b1;
        rf_addr = md_addr;
        rf_data = md_data;
      end
    end
  end

  always_comb begin
    rs_pending = 1'b0;
    rt_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == rs_addr)) rs_pending = 1'b1;
      if (live_q[i] && (addr_q[i] == rt_addr)) rt_pending = 1'b1;
    end
    if (rs_addr == '0) rs_pending = 1'b0;
    if (rt_addr == '0) rt_pending = 1'b0;
  end

  always_comb begin
    live_d   = live_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = '0;
    stall_d  = 1'b0;
    // A younger WB write to the same register makes the buffered result stale.
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_act && live_q[i] && (addr_q[i] == wb_addr)) live_d[i] = 1'b0;
    end
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (!fifo_empty && !grant_head) begin
      if (starve_q == STV_LAST) stall_d = 1'b1;
      else                      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // NOTE: payload storage is not reset; live bits and count decide whether an entry means anything.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= md_addr;
      data_q[wr_ptr_q] <= md_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-cycle expected rf writes go through a scoreboard queue.
module tb_regfile_wb_arbiter;

  localparam bit BYP =
`ifdef RF_ARB_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk, rst_n;
  logic        wb_we, md_valid, md_ready;
  logic [4:0]  wb_addr, md_addr, rs_addr, rt_addr, rf_addr;
  logic [31:0] wb_data, md_data, rf_data;
  logic        rs_pending, rt_pending, rf_we, stall_req, busy;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_pending(rs_pending), .rt_pending(rt_pending),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .stall_req(stall_req), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each cycle's expected write port value, consumed on the falling edge.
  always @(negedge clk) begin
    wr_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rf_we", 64'(rf_we), 64'(e.we));
      if (e.we) begin
        check("rf_addr", 64'(rf_addr), 64'(e.addr));
        check("rf_data", 64'(rf_data), 64'(e.data));
      end
    end
  end

  task automatic drive(input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] mdd,
                       input logic ew, input logic [4:0] ea, input logic [31:0] ed);
    wb_we = wbe; wb_addr = wba; wb_data = wbd;
    md_valid = mv; md_addr = ma; md_data = mdd;
    exp_q.push_back('{we: ew, addr: ea, data: ed});
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    md_valid = 1'b1; md_addr = 5'd3; md_data = 32'h33; rs_addr = '0; rt_addr = '0;
    repeat (2) begin
      mid();
      check("rst_rf_we", 64'(rf_we), 64'd0);
      check("rst_md_ready", 64'(md_ready), 64'd0);
    end
    fin();

    // Release
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    check("rel_busy", 64'(busy), 64'd0);
    check("rel_stall", 64'(stall_req), 64'd0);
    check("rel_md_ready", 64'(md_ready), 64'd1);
    fin();

    // Idle-slot drain
    drive(0, 0, 0, 1, 5'd8, 32'h12345678, BYP, 5'd8, 32'h12345678);
    mid(); check("drain_md_ready", 64'(md_ready), 64'd1); fin();
    drive(0, 0, 0, 0, 0, 0, !BYP, 5'd8, 32'h12345678);
    mid(); check("drain_busy", 64'(busy), 64'(!BYP)); fin();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid(); check("drain_busy_after", 64'(busy), 64'd0); fin();

    // $0 result accepted, not buffered
    drive(0, 0, 0, 1, 5'd0, 32'hdead, 0, 0, 0);
    mid(); check("zero_md_ready", 64'(md_ready), 64'd1); fin();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid(); check("zero_busy", 64'(busy), 64'd0); fin();

    // Full FIFO under continuous WB, then starvation stall
    rs_addr = 5'd3; rt_addr = 5'd4;
    drive(1, 5'd9, 32'h901, 1, 5'd3, 32'h33, 1, 5'd9, 32'h901);
    mid(); check("full_rdy0", 64'(md_ready), 64'd1); fin();
    drive(1, 5'd9, 32'h902, 1, 5'd4, 32'h44, 1, 5'd9, 32'h902);
    mid();
    check("full_rdy1", 64'(md_ready), 64'd1);
    check("full_rs_pend", 64'(rs_pending), 64'd1);
    check("incoming_not_pend", 64'(rt_pending), 64'd0);
    fin();
    drive(1, 5'd9, 32'h903, 0, 0, 0, 1, 5'd9, 32'h903);
    mid();
    check("full_rdy2", 64'(md_ready), 64'd0);
    check("full_rt_pend", 64'(rt_pending), 64'd1);
    check("starve_c2", 64'(stall_req), 64'd0);
    fin();
    drive(1, 5'd9, 32'h904, 0, 0, 0, 1, 5'd9, 32'h904);
    mid(); check("starve_c3", 64'(stall_req), 64'd0); fin();
    drive(1, 5'd9, 32'h905, 0, 0, 0, 1, 5'd9, 32'h905);
    mid(); check("starve_c4", 64'(stall_req), 64'd0); fin();
    drive(1, 5'd9, 32'h906, 0, 0, 0, 1, 5'd3, 32'h33);
    mid(); check("starve_c5", 64'(stall_req), 64'd1); fin();
    drive(1, 5'd9, 32'h906, 0, 0, 0, 1, 5'd9, 32'h906);
    mid();
    check("stall_one_cycle", 64'(stall_req), 64'd0);
    check("post_pop_rdy", 64'(md_ready), 64'd1);
    check("post_pop_rs", 64'(rs_pending), 64'd0);
    check("post_pop_rt", 64'(rt_pending), 64'd1);
    fin();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd4, 32'h44);
    mid(); fin();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid(); check("full_busy_end", 64'(busy), 64'd0); fin();

    // Squash by younger WB write
    rs_addr = 5'd0; rt_addr = 5'd5;
    drive(1, 5'd10, 32'h1010, 1, 5'd5, 32'hAAAA, 1, 5'd10, 32'h1010);
    mid(); fin();
    drive(1, 5'd5, 32'hBBBB, 0, 0, 0, 1, 5'd5, 32'hBBBB);
    mid(); check("sq_pend_before", 64'(rt_pending), 64'd1); fin();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    check("sq_pend_after", 64'(rt_pending), 64'd0);
    check("sq_busy", 64'(busy), 64'd1);
    fin();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid(); check("sq_busy_end", 64'(busy), 64'd0); fin();

    // Same-cycle push to the squashed address survives
    rt_addr = 5'd12;
    drive(1, 5'd11, 32'h1111, 1, 5'd12, 32'hC1, 1, 5'd11, 32'h1111);
    mid(); fin();
    drive(1, 5'd12, 32'hC0C0, 1, 5'd12, 32'hC2, 1, 5'd12, 32'hC0C0);
    mid(); check("sq2_rdy", 64'(md_ready), 64'd1); fin();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid(); check("sq2_new_pend", 64'(rt_pending), 64'd1); fin();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd12, 32'hC2);
    mid(); fin();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid(); check("sq2_busy_end", 64'(busy), 64'd0); fin();

    // Reset mid-drain discards buffered results
    rt_addr = 5'd14;
    drive(1, 5'd13, 32'hD, 1, 5'd14, 32'hE, 1, 5'd13, 32'hD);
    mid(); fin();
    rst_n = 1'b0; wb_we = 1'b1; md_valid = 1'b0;
    mid();
    check("mid_rst_rf_we", 64'(rf_we), 64'd0);
    check("mid_rst_md_ready", 64'(md_ready), 64'd0);
    fin();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_pend", 64'(rt_pending), 64'd0);
    fin();

    // Bypass candidate: empty FIFO, idle WB
    drive(0, 0, 0, 1, 5'd7, 32'h1, BYP, 5'd7, 32'h1);
    mid(); fin();
    drive(0, 0, 0, 0, 0, 0, !BYP, 5'd7, 32'h1);
    mid(); fin();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid(); check("byp_busy_end", 64'(busy), 64'd0); fin();

    mid();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
